// File: rtl/cwc_capture_core.sv
// On-chip logic-analyzer capture: circular sample buffer, per-bit level/edge trigger, pre/post-trigger fill.
// Frozen buffer is read by logical index (0 = oldest) with one cycle of latency.
module cwc_capture_core #(
  parameter int PROBE_W = 24,
  parameter int DEPTH   = 1024,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PROBE_W-1:0] probe,
  input  logic               arm,
  input  logic               abort,
  input  logic [PROBE_W-1:0] trig_mask,
  input  logic [PROBE_W-1:0] trig_value,
  input  logic [PROBE_W-1:0] trig_edge,
  input  logic [AW-1:0]      pretrig_len,
  output logic               busy,
  output logic               triggered,
  output logic               done,
  output logic [AW-1:0]      trig_addr,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [PROBE_W-1:0] rd_data,
  output logic               rd_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WAIT,
    S_POST,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [PROBE_W-1:0] s_cur_q, s_prev_q;
  logic               prev_valid_q;
  logic [PROBE_W-1:0] mask_q, value_q, tedge_q;
  logic [AW-1:0]      pre_q, wr_ptr_q, cnt_q, post_q, trig_addr_q;
  logic               busy_q, triggered_q, done_q, rd_valid_q;
  logic [PROBE_W-1:0] rd_data_q;

  logic [PROBE_W-1:0] mem [DEPTH];

  logic [PROBE_W-1:0] term_fail;
  logic               hit;
  logic               we;
  logic [AW-1:0]      wr_ptr_d, cnt_d, post_d, post_init, rd_phys;

  // A masked bit fails if its level is wrong, or if an edge is required and none was seen.
  always_comb begin
    term_fail = mask_q & ((s_cur_q ^ value_q) |
                          (tedge_q & ~({PROBE_W{prev_valid_q}} & (s_prev_q ^ s_cur_q))));
    hit       = ~|term_fail;
  end

  assign we        = (state_q == S_FILL) || (state_q == S_WAIT) || (state_q == S_POST);
  assign wr_ptr_d  = wr_ptr_q + AW'(1);
  assign cnt_d     = cnt_q + AW'(1);
  assign post_d    = post_q - AW'(1);
  assign post_init = AW'(DEPTH - 1) - pre_q;
  assign rd_phys   = trig_addr_q - pre_q + rd_addr;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr_q] <= s_cur_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      s_cur_q      <= '0;
      s_prev_q     <= '0;
      prev_valid_q <= 1'b0;
      mask_q       <= '0;
      value_q      <= '0;
      tedge_q      <= '0;
      pre_q        <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      post_q       <= '0;
      trig_addr_q  <= '0;
      busy_q       <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      s_cur_q    <= probe;
      s_prev_q   <= s_cur_q;
      rd_valid_q <= 1'b0;
      if (rd_en && state_q == S_DONE) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= mem[rd_phys];
      end

      if (we) begin
        wr_ptr_q     <= wr_ptr_d;
        prev_valid_q <= 1'b1;
      end

      if (abort) begin
        state_q     <= S_IDLE;
        busy_q      <= 1'b0;
        triggered_q <= 1'b0;
        done_q      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (arm) begin
              mask_q       <= trig_mask;
              value_q      <= trig_value;
              tedge_q      <= trig_edge;
              pre_q        <= pretrig_len;
              wr_ptr_q     <= '0;
              cnt_q        <= '0;
              prev_valid_q <= 1'b0;
              busy_q       <= 1'b1;
              triggered_q  <= 1'b0;
              done_q       <= 1'b0;
              state_q      <= (pretrig_len == '0) ? S_WAIT : S_FILL;
            end
          end
          S_FILL: begin
            cnt_q <= cnt_d;
            if (cnt_d == pre_q) begin
              state_q <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (hit) begin
              trig_addr_q <= wr_ptr_q;
              triggered_q <= 1'b1;
              post_q      <= post_init;
              if (post_init == '0) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_POST;
              end
            end
          end
          S_POST: begin
            post_q <= post_d;
            if (post_q == AW'(1)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign triggered = triggered_q;
  assign done      = done_q;
  assign trig_addr = trig_addr_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_cwc_capture_core.sv
// Directed bench for cwc_capture_core at PROBE_W=8, DEPTH=16.
module tb_cwc_capture_core;
  localparam int PW = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] probe;
  logic          arm, abort;
  logic [PW-1:0] trig_mask, trig_value, trig_edge;
  logic [AW-1:0] pretrig_len;
  logic          busy, triggered, done;
  logic [AW-1:0] trig_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_data;
  logic          rd_valid;

  int checks = 0;
  int errors = 0;
  bit count_en = 1'b0;

  cwc_capture_core #(.PROBE_W(PW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .probe(probe), .arm(arm), .abort(abort),
    .trig_mask(trig_mask), .trig_value(trig_value), .trig_edge(trig_edge),
    .pretrig_len(pretrig_len), .busy(busy), .triggered(triggered), .done(done),
    .trig_addr(trig_addr), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (count_en) probe = probe + 8'd1;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (done !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic read_idx(input int a);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    tick();
    rd_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; probe = '0; arm = 1'b0; abort = 1'b0; rd_en = 1'b0; rd_addr = '0;
    trig_mask = '0; trig_value = '0; trig_edge = '0; pretrig_len = '0;
    #12;
    checks++;
    if ({busy, triggered, done, rd_valid} !== 4'b0 || trig_addr !== 4'h0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b trig=%b done=%b rdv=%b taddr=%h rdata=%h, required all 0",
               busy, triggered, done, rd_valid, trig_addr, rd_data);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_count_capture();
    int n;
    trig_mask = 8'hFF; trig_value = 8'h2A; trig_edge = 8'h00; pretrig_len = 4'd4;
    probe = 8'h00; count_en = 1'b1;
    arm_pulse();
    trig_mask = 8'h00; trig_value = 8'h00; pretrig_len = 4'd9;
    wait_done(200, n);
    count_en = 1'b0;
    checks++;
    if (n != 54) begin errors++; $display("FAIL count_done_cycle: got %0d, required 54", n); end
    checks++;
    if (triggered !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL count_flags: trig=%b busy=%b, required 1/0", triggered, busy);
    end
    checks++;
    if (trig_addr !== 4'hA) begin errors++; $display("FAIL count_trig_addr: got %h, required a", trig_addr); end
    for (int j = 0; j < D; j++) begin
      read_idx(j);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(8'h26 + j)) begin
        errors++;
        $display("FAIL count_read[%0d]: valid=%b data=%h, required 1/%h", j, rd_valid, rd_data, 8'(8'h26 + j));
      end
    end
  endtask

  task automatic test_pretrig0();
    int n;
    trig_mask = 8'h00; trig_value = 8'h00; trig_edge = 8'h00; pretrig_len = 4'd0;
    probe = 8'h00; count_en = 1'b1;
    arm_pulse();
    wait_done(200, n);
    count_en = 1'b0;
    checks++;
    if (n != 16) begin errors++; $display("FAIL p0_done_cycle: got %0d, required 16", n); end
    checks++;
    if (trig_addr !== 4'h0 || triggered !== 1'b1) begin
      errors++; $display("FAIL p0_trig: addr=%h trig=%b, required 0/1", trig_addr, triggered);
    end
    for (int j = 0; j < D; j++) begin
      read_idx(j);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(j)) begin
        errors++; $display("FAIL p0_read[%0d]: valid=%b data=%h, required 1/%h", j, rd_valid, rd_data, 8'(j));
      end
    end
  endtask

  task automatic test_edge();
    int dk;
    logic b;
    trig_mask = 8'h01; trig_value = 8'h01; trig_edge = 8'h01; pretrig_len = 4'd0;
    probe = 8'h01; count_en = 1'b0;
    arm_pulse();
    dk = -1;
    for (int k = 1; k <= 40 && dk < 0; k++) begin
      b = (k < 2) ? 1'b1 : ((k < 5) ? 1'b0 : 1'b1);
      probe = 8'((k << 1) | int'(b));
      tick();
      if (k == 5) begin
        checks++;
        if (triggered !== 1'b0) begin errors++; $display("FAIL edge_no_early_trig: got %b, required 0", triggered); end
      end
      if (k == 6) begin
        checks++;
        if (triggered !== 1'b1 || trig_addr !== 4'h5) begin
          errors++; $display("FAIL edge_trig: trig=%b addr=%h, required 1/5", triggered, trig_addr);
        end
      end
      if (done === 1'b1) dk = k;
    end
    checks++;
    if (dk != 21) begin errors++; $display("FAIL edge_done_cycle: got %0d, required 21", dk); end
    for (int j = 0; j < D; j++) begin
      read_idx(j);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(((5 + j) << 1) | 1)) begin
        errors++;
        $display("FAIL edge_read[%0d]: valid=%b data=%h, required 1/%h", j, rd_valid, rd_data, 8'(((5 + j) << 1) | 1));
      end
    end
  endtask

  task automatic test_pretrig15();
    int n;
    trig_mask = 8'hFF; trig_value = 8'h2A; trig_edge = 8'h00; pretrig_len = 4'd15;
    probe = 8'h00; count_en = 1'b1;
    arm_pulse();
    wait_done(200, n);
    count_en = 1'b0;
    checks++;
    if (n != 43) begin errors++; $display("FAIL p15_done_cycle: got %0d, required 43", n); end
    checks++;
    if (trig_addr !== 4'hA || triggered !== 1'b1) begin
      errors++; $display("FAIL p15_trig: addr=%h trig=%b, required a/1", trig_addr, triggered);
    end
    for (int j = 0; j < D; j++) begin
      read_idx(j);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(8'h1B + j)) begin
        errors++; $display("FAIL p15_read[%0d]: valid=%b data=%h, required 1/%h", j, rd_valid, rd_data, 8'(8'h1B + j));
      end
    end
  endtask

  task automatic test_abort();
    trig_mask = 8'hFF; trig_value = 8'hFF; trig_edge = 8'h00; pretrig_len = 4'd0;
    probe = 8'h00; count_en = 1'b0;
    arm_pulse();
    tick(); tick(); tick();
    checks++;
    if (busy !== 1'b1 || triggered !== 1'b0) begin
      errors++; $display("FAIL abort_wait_busy: busy=%b trig=%b, required 1/0", busy, triggered);
    end
    abort = 1'b1; arm = 1'b1;
    tick();
    abort = 1'b0; arm = 1'b0;
    checks++;
    if ({busy, done, triggered} !== 3'b000) begin
      errors++; $display("FAIL abort_flags: busy=%b done=%b trig=%b, required 000", busy, done, triggered);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_over_arm: busy=%b, required 0", busy); end
    read_idx(0);
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL abort_read: rd_valid=%b, required 0", rd_valid); end
    test_pretrig0();
  endtask

  task automatic test_rst_mid_post();
    int n;
    trig_mask = 8'hFF; trig_value = 8'h2A; trig_edge = 8'h00; pretrig_len = 4'd4;
    probe = 8'h00; count_en = 1'b1;
    arm_pulse();
    n = 0;
    while (triggered !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (triggered !== 1'b1) begin errors++; $display("FAIL rst_pre_trigger: trig=%b, required 1", triggered); end
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, triggered, done, rd_valid} !== 4'b0 || trig_addr !== 4'h0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_async: busy=%b trig=%b done=%b rdv=%b taddr=%h rdata=%h, required all 0",
               busy, triggered, done, rd_valid, trig_addr, rd_data);
    end
    @(negedge clk);
    rst = 1'b0;
    count_en = 1'b0;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_stays_idle: busy=%b done=%b, required 0/0", busy, done);
    end
    test_count_capture();
  endtask

  initial begin
    test_reset();
    test_count_capture();
    test_pretrig0();
    test_edge();
    test_pretrig15();
    test_abort();
    test_rst_mid_post();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
